// File: rtl/fpu_pkg.sv
// Shared FPU constants and the binary32 field layout.
package fpu_pkg;

    localparam int unsigned BIAS  = 127;
    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } float32_t;

endpackage

// File: rtl/lzc32.sv
// Leading-zero count of a 32-bit word; an all-zero word counts as 32.
module lzc32 (
    input  logic [31:0] in_i,
    output logic [5:0]  cnt_o
);

    // Scan upward so the highest set bit has the final say.
    always_comb begin
        cnt_o = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (in_i[i]) begin
                cnt_o = 6'(31 - i);
            end
        end
    end

endmodule

// File: rtl/itof.sv
// Signed 32-bit integer to binary32 converter, 3-stage pipeline, round-to-nearest-even.
module itof
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] y,
    output logic        out_valid,
    input  logic        out_ready
);

    logic        adv;
    logic        v1_q, v2_q, v3_q;
    logic        sign1_q, sign2_q, zero2_q;
    logic [31:0] mag1_q, norm2_q;
    logic [7:0]  exp2_q;
    logic [5:0]  lz;
    float32_t    y_q, y_d;

    // Whole-pipe stall: everything moves together or nothing does.
    assign adv       = !v3_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = v3_q;
    assign y         = y_q;

    lzc32 u_lzc (
        .in_i  (mag1_q),
        .cnt_o (lz)
    );

    logic [22:0] man_t;
    logic        guard, sticky, rnd, carry;
    logic [22:0] man_r;
    logic [7:0]  exp_r;

    always_comb begin
        man_t          = norm2_q[30:8];
        guard          = norm2_q[7];
        sticky         = |norm2_q[6:0];
        rnd            = guard && (sticky || man_t[0]);
        {carry, man_r} = {1'b0, man_t} + 24'(rnd);
        exp_r          = exp2_q + 8'(carry);
        y_d            = '0;
        if (!zero2_q) begin
            y_d.sign = sign2_q;
            y_d.exp  = exp_r;
            y_d.man  = man_r;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            y_q  <= '0;
        end else if (adv) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (v2_q) begin
                y_q <= y_d;
            end
        end
    end

    // Datapath carries no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (adv) begin
            sign1_q <= x[31];
            mag1_q  <= x[31] ? (~x + 32'd1) : x;
            sign2_q <= sign1_q;
            zero2_q <= (mag1_q == 32'd0);
            norm2_q <= mag1_q << lz;
            exp2_q  <= 8'(BIAS + 31) - {2'b00, lz};
        end
    end

endmodule

// File: tb/tb_itof.sv
// Scoreboard bench for itof: directed values, backpressure, mid-stream reset, random traffic.
module tb_itof;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] x = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] y;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic lat_chk = 1'b1;
    logic rnd_done = 1'b0;

    typedef struct {
        logic        chk;
        int          cyc;
        logic [31:0] y;
    } exp_t;

    exp_t sb[$];

    itof dut (
        .clk       (clk),
        .rstn      (rstn),
        .x         (x),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Independent reference: quotient/remainder rounding on a 64-bit magnitude.
    function automatic logic [31:0] model(input logic [31:0] xv);
        logic [63:0] m, q, r, half;
        int          p, sh;
        logic        s;
        if (xv == 32'd0) return 32'd0;
        s = xv[31];
        m = s ? (64'h1_0000_0000 - {32'd0, xv}) : {32'd0, xv};
        p = 63;
        while (!m[p]) p--;
        if (p <= 23) begin
            q = m << (23 - p);
        end else begin
            sh   = p - 23;
            q    = m >> sh;
            r    = m - (q << sh);
            half = 64'd1 << (sh - 1);
            if (r > half || (r == half && q[0])) q = q + 64'd1;
            if (q[24]) begin
                q = q >> 1;
                p++;
            end
        end
        return {s, 8'(127 + p), q[22:0]};
    endfunction

    // Output side: compare each transfer against the oldest expectation.
    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL extra_out: got %h want none", y);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                total++;
                assert (y === e.y) else begin
                    bad++;
                    $error("FAIL result: got %h want %h", y, e.y);
                end
                if (e.chk) begin
                    total++;
                    assert (cyc - e.cyc === 3) else begin
                        bad++;
                        $error("FAIL latency: got %0d want 3", cyc - e.cyc);
                    end
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send(input logic [31:0] xv, input logic [31:0] ev);
        int   n = 0;
        logic done = 1'b0;
        x        = xv;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{chk: lat_chk, cyc: cyc, y: ev});
                done = 1'b1;
            end else if (++n > 200) begin
                total++;
                bad++;
                $error("FAIL accept_timeout: got in_ready=0 want 1");
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL drain: got %0d pending want 0", sb.size());
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] rv;

        // Reset state
        tick(3);
        total++;
        assert (out_valid === 1'b0) else begin
            bad++; $error("FAIL rst_out_valid: got %b want 0", out_valid);
        end
        total++;
        assert (y === 32'h0) else begin
            bad++; $error("FAIL rst_y: got %h want 00000000", y);
        end
        total++;
        assert (in_ready === 1'b1) else begin
            bad++; $error("FAIL rst_in_ready: got %b want 1", in_ready);
        end
        rstn = 1'b1;
        tick(2);

        // Directed exact values, extremes and ties
        send(32'd1,          32'h3F80_0000);
        send(32'hFFFF_FFFF,  32'hBF80_0000);
        send(32'd0,          32'h0000_0000);
        send(32'd16777216,   32'h4B80_0000);
        send(32'h7FFF_FFFF,  32'h4F00_0000);
        send(32'h8000_0000,  32'hCF00_0000);
        send(32'd16777217,   32'h4B80_0000);
        send(32'd16777219,   32'h4B80_0002);
        send(-32'sd16777219, 32'hCB80_0002);
        send(32'd3,          32'h4040_0000);
        send(-32'sd10,       32'hC120_0000);
        drain();

        // Backpressure: 8 back-to-back, consumer stalls 5 cycles mid-stream
        lat_chk = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(32'(i * 1000 + 7), model(32'(i * 1000 + 7)));
            end
            begin
                tick(4);
                out_ready = 1'b0;
                @(negedge clk);
                held = y;
                for (int k = 0; k < 5; k++) begin
                    total++;
                    assert (in_ready === 1'b0 && out_valid === 1'b1) else begin
                        bad++;
                        $error("FAIL stall_ready: got in_ready=%b want 0", in_ready);
                    end
                    total++;
                    assert (y === held) else begin
                        bad++; $error("FAIL stall_y: got %h want %h", y, held);
                    end
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three results in flight
        lat_chk = 1'b1;
        send(32'd100, model(32'd100));
        send(32'd200, model(32'd200));
        send(32'd300, model(32'd300));
        rstn = 1'b0;
        #1;
        sb.delete();
        total++;
        assert (out_valid === 1'b0 && y === 32'h0) else begin
            bad++; $error("FAIL mid_rst: got valid=%b y=%h want 0", out_valid, y);
        end
        tick(2);
        rstn = 1'b1;
        tick(1);
        send(32'd5,         32'h40A0_0000);
        send(-32'sd123456,  model(-32'sd123456));
        drain();

        // Random traffic with input gaps and consumer stalls
        lat_chk = 1'b0;
        fork
            begin
                for (int i = 0; i < 3000; i++) begin
                    tick($urandom_range(0, 2));
                    rv = $urandom;
                    case ($urandom_range(0, 3))
                        0: rv = rv >> $urandom_range(0, 31);
                        1: rv = -(rv >> $urandom_range(0, 31));
                        default: ;
                    endcase
                    send(rv, model(rv));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
